// File: rtl/secuenciador_multiciclo_if.sv
// Sequencer-to-datapath bundle: instruction fetch handshake plus the registered
// control strobes that drive the register bank, ALU, data demux and data RAM.
interface secuenciador_multiciclo_if #(
    parameter int unsigned PC_W    = 6,
    parameter int unsigned INSTR_W = 16
);
    logic               instr_req;
    logic [PC_W-1:0]    pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_in;
    logic [2:0]         op_code;
    logic               wEnable_BR;
    logic               SEL_dmx;
    logic [3:0]         OP_alu;
    logic               W_ram;
    logic               R_ram;

    modport master (
        output instr_req,
        output pc,
        input  instr_valid,
        input  instr_in,
        output op_code,
        output wEnable_BR,
        output SEL_dmx,
        output OP_alu,
        output W_ram,
        output R_ram
    );

    modport slave (
        input  instr_req,
        input  pc,
        output instr_valid,
        output instr_in,
        input  op_code,
        input  wEnable_BR,
        input  SEL_dmx,
        input  OP_alu,
        input  W_ram,
        input  R_ram
    );
endinterface

// File: rtl/secuenciador_multiciclo.sv
// Multi-cycle instruction sequencer: fetches over a req/valid handshake and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB/NEXT with registered (Moore) strobes.
module secuenciador_multiciclo #(
    parameter int unsigned PC_W    = 6,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [PC_W-1:0]            prog_len,
    secuenciador_multiciclo_if.master  bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    localparam logic [2:0] OpAdd   = 3'b000;
    localparam logic [2:0] OpSub   = 3'b001;
    localparam logic [2:0] OpSlt   = 3'b010;
    localparam logic [2:0] OpStore = 3'b011;
    localparam logic [2:0] OpLoad  = 3'b100;

    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluStore = 4'b1111;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StNext,
        StDone,
        StErr
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    len_q, len_d;
    logic [PC_W-1:0]    pc_inc;
    logic [2:0]         op_code_q, op_code_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [3:0]         op_alu_q, op_alu_d;
    logic               sel_dmx_q, sel_dmx_d;
    logic               instr_req_q, instr_req_d;
    logic               w_ram_q, w_ram_d;
    logic               r_ram_q, r_ram_d;
    logic               we_br_q, we_br_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        op_code_d = op_code_q;
        lat_d     = lat_q;
        op_alu_d  = op_alu_q;
        sel_dmx_d = sel_dmx_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    state_d = (prog_len == '0) ? StDone : StFetch;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StFetch: begin
                if (bus.instr_valid) begin
                    op_code_d = bus.instr_in[INSTR_W-1 -: 3];
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                state_d = StExec;
                case (op_code_q)
                    OpAdd:   begin op_alu_d = AluAdd;   sel_dmx_d = 1'b0; end
                    OpSub:   begin op_alu_d = AluSub;   sel_dmx_d = 1'b0; end
                    OpSlt:   begin op_alu_d = AluSlt;   sel_dmx_d = 1'b0; end
                    OpStore: begin op_alu_d = AluStore; sel_dmx_d = 1'b1; end
                    OpLoad:  begin op_alu_d = AluSlt;   sel_dmx_d = 1'b1; end
                    default: state_d = StErr;
                endcase
            end
            StExec: begin
                lat_d   = LAT_W'(RAM_LAT - 1);
                state_d = (op_code_q == OpStore || op_code_q == OpLoad) ? StMem : StWb;
            end
            StMem: begin
                // STORE spends one cycle here; LOAD counts down the RAM read latency
                if (op_code_q == OpStore) begin
                    state_d = StNext;
                end else if (lat_q == '0) begin
                    state_d = StWb;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            StWb: begin
                state_d = StNext;
            end
            StNext: begin
                pc_d    = pc_inc;
                state_d = (pc_inc == len_q) ? StDone : StFetch;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // ALU op and demux select are only meaningful while an instruction is executing
        if (!(state_d inside {StExec, StMem, StWb})) begin
            op_alu_d  = '0;
            sel_dmx_d = 1'b0;
        end

        instr_req_d = (state_d == StFetch);
        w_ram_d     = (state_d == StMem) && (op_code_d == OpStore);
        r_ram_d     = (state_d == StMem) && (op_code_d == OpLoad);
        we_br_d     = (state_d == StWb);
        busy_d      = state_d inside {StFetch, StDecode, StExec, StMem, StWb, StNext};
        done_d      = (state_d == StDone);
        err_d       = (state_d == StErr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            len_q       <= '0;
            op_code_q   <= '0;
            lat_q       <= '0;
            op_alu_q    <= '0;
            sel_dmx_q   <= 1'b0;
            instr_req_q <= 1'b0;
            w_ram_q     <= 1'b0;
            r_ram_q     <= 1'b0;
            we_br_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            op_code_q   <= op_code_d;
            lat_q       <= lat_d;
            op_alu_q    <= op_alu_d;
            sel_dmx_q   <= sel_dmx_d;
            instr_req_q <= instr_req_d;
            w_ram_q     <= w_ram_d;
            r_ram_q     <= r_ram_d;
            we_br_q     <= we_br_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.instr_req  = instr_req_q;
    assign bus.pc         = pc_q;
    assign bus.op_code    = op_code_q;
    assign bus.wEnable_BR = we_br_q;
    assign bus.SEL_dmx    = sel_dmx_q;
    assign bus.OP_alu     = op_alu_q;
    assign bus.W_ram      = w_ram_q;
    assign bus.R_ram      = r_ram_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: doc/secuenciador_multiciclo.md
Name: secuenciador_multiciclo

Overview:
- Multi-cycle instruction sequencer that drives the register bank, ALU, data demux and data RAM.
- Holds a program counter and fetches instruction words over a request/valid handshake.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues registered control strobes, one per phase.
- Sits between instruction memory and the datapath. Its control outputs replace the purely combinational opcode decode.

Parameters:
PC_W, 6, program counter / program length width
INSTR_W, 16, instruction word width; opcode = instr[INSTR_W-1 -: 3]
RAM_LAT, 2, data RAM read latency in cycles (>=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin program at pc=0; sampled only in IDLE/DONE/ERR
prog_len  input  PC_W  instruction count, sampled on accepted start
instr_req  output  1  fetch request to instruction memory
pc  output  PC_W  fetch address
instr_valid  input  1  instr_in valid this cycle
instr_in  input  INSTR_W  instruction word
op_code  output  3  latched opcode (IR field), for datapath field decode
wEnable_BR  output  1  register bank write strobe
SEL_dmx  output  1  0 = ALU result path, 1 = RAM path
OP_alu  output  4  ALU operation
W_ram  output  1  RAM write strobe
R_ram  output  1  RAM read enable
busy  output  1  high from accepted start until DONE/ERR
done  output  1  one-cycle pulse at program end
err  output  1  sticky illegal-opcode flag

Behaviour:
- Asynchronous reset (rst_n=0): state=IDLE; pc=0; op_code=0; OP_alu=4'b0000; all 1-bit outputs 0. Reset mid-instruction aborts with no further strobes.
- All outputs are registered (Moore). No combinational input-to-output paths.
- IDLE: start=1 latches prog_len and clears pc and err. If prog_len=0, go to DONE; otherwise go to FETCH.
- FETCH: instr_req=1, pc stable. Wait indefinitely for instr_valid. On instr_valid, latch the IR and go to DECODE. instr_req drops the cycle after acceptance.
- DECODE (1 cycle):
  - 000 ADD: OP_alu=0010, SEL_dmx=0
  - 001 SUB: OP_alu=0110, SEL_dmx=0
  - 010 SLT: OP_alu=0111, SEL_dmx=0
  - 011 STORE: OP_alu=1111, SEL_dmx=1
  - 100 LOAD: OP_alu=0111, SEL_dmx=1
  - 101-111: go to ERR; no strobes issued.
- OP_alu and SEL_dmx are set on DECODE exit and held constant through EXEC, MEM and WB. They return to 0 in NEXT.
- EXEC (1 cycle): ALU settles. ADD/SUB/SLT go to WB; STORE/LOAD go to MEM.
- MEM:
  - STORE: W_ram=1 for exactly 1 cycle, then NEXT.
  - LOAD: R_ram=1 for exactly RAM_LAT cycles (internal latency counter), then WB.
- WB: wEnable_BR=1 for exactly 1 cycle (ALU ops and LOAD only; never STORE), then NEXT.
- NEXT: pc=pc+1. If the new pc equals the latched prog_len, go to DONE; otherwise go to FETCH.
- pc width arithmetic: prog_len=2^PC_W-1 is the maximum; pc never wraps.
- Instruction latency, with instr_valid in the first FETCH cycle:
  - ALU op: 5 cycles
  - STORE: 5 cycles
  - LOAD: 5+RAM_LAT cycles
- DONE: done=1 for one cycle, busy=0. Go to IDLE; if start=1 in that cycle, restart directly (latch prog_len, pc=0).
- ERR: err=1 held, busy=0, pc frozen at the faulting instruction. Stay until start=1, which clears err and restarts as from IDLE.
- start while busy: ignored.
- instr_valid outside FETCH: ignored.
- busy: 1 in FETCH through NEXT; 0 in IDLE, DONE and ERR.
- At most one of W_ram, R_ram and wEnable_BR is high in any cycle.

Test Plan:
- Reset then idle: rst_n low mid-LOAD (R_ram=1) -> all outputs 0 immediately (async), pc=0, no strobes after release until start.
- prog_len=3, instrs ADD, SUB, SLT, instr_valid same cycle as instr_req:
  - wEnable_BR pulses at cycles 4, 9 and 14 after start.
  - OP_alu shows 0010, 0110, 0111 respectively.
  - done pulses once; busy low afterwards.
- prog_len=2, STORE then LOAD, RAM_LAT=2:
  - STORE: W_ram 1 cycle, wEnable_BR never during STORE.
  - LOAD: R_ram 2 consecutive cycles, then wEnable_BR 1 cycle.
  - SEL_dmx=1 through both instructions.
- Fetch stall: instr_valid delayed 4 cycles -> instr_req and pc held, no strobes; instruction completes 4 cycles later than nominal.
- Illegal opcode 110 at pc=1 -> ERR, err=1 sticky, pc=1, no strobes. start pulse clears err and refetches from pc=0.
- Boundary: prog_len=0 -> done pulses 1 cycle after start with no fetch. start asserted while busy -> ignored, pc sequence unchanged.
